// File: rtl/la_cfgchain_ctrl_pkg.sv
// Shared types and helpers for the config chain sequencer.
// State encoding is also used by the chain bench model.
package la_cfgchain_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2,
    RESP   = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/la_cfgchain_ctrl_if.sv
// Request/response handshake bundle for the chain sequencer.
// Master drives the config word, slave returns the readback.
interface la_cfgchain_ctrl_if #(
  parameter int N = 32
) ();

  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/la_cfgchain_ctrl_shreg.sv
// Load/shift-out register and indexed readback capture.
// Both paths compensate for inverting chain stages.
module la_cfgchain_ctrl_shreg
  import la_cfgchain_ctrl_pkg::*;
#(
  parameter int N   = 32,
  parameter bit INV = 1'b0,
  localparam int CW = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [N-1:0]  word,
  input  logic [CW-1:0] cnt,
  input  logic          chain_q,
  output logic          chain_d,
  output logic [N-1:0]  cap
);

  logic [N-1:0]  mask;
  logic [N-1:0]  sh;
  logic [CW-1:0] idx;

  // A bit landing in stage j passes j+1 inverters.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++)
      mask[i] = INV & (i % 2 == 0);
  end

  assign idx     = CW'(N - 1) - cnt;
  assign chain_d = sh[N-1];

  // MSB-first shift-out; drains to zero, so chain_d idles low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sh <= '0;
    else if (load)
      sh <= word ^ mask;
    else if (shift)
      sh <= {sh[N-2:0], 1'b0};
  end

  // Old stage N-1-cnt appears on chain_q after cnt inversions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cap <= '0;
    else if (shift)
      cap[idx] <= chain_q ^ (INV & cnt[0]);
  end

endmodule

// File: rtl/la_cfgchain_ctrl.sv
// Config chain sequencer: shifts a word into N chain flops,
// strobes update, and returns the previous chain contents.
module la_cfgchain_ctrl
  import la_cfgchain_ctrl_pkg::*;
#(
  parameter int N    = 32,
  parameter bit INV  = 1'b0,
  parameter     PROP = "DEFAULT"
) (
  input  logic               clk,
  input  logic               reset,
  la_cfgchain_ctrl_if.slave  bus,
  output logic               chain_en,
  output logic               chain_d,
  input  logic               chain_q,
  output logic               chain_upd,
  output logic               busy
);

  localparam int CW = clog2(N);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          load;
  logic          shift;

  assign load  = (state == IDLE) & bus.req_valid & bus.req_ready;
  assign shift = (state == SHIFT);

  // Sequencer FSM with registered handshake and chain controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      chain_en      <= 1'b0;
      chain_upd     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            state         <= SHIFT;
            cnt           <= '0;
            bus.req_ready <= 1'b0;
            chain_en      <= 1'b1;
            busy          <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == CW'(N - 1)) begin
            state     <= UPDATE;
            cnt       <= '0;
            chain_en  <= 1'b0;
            chain_upd <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        UPDATE: begin
          state         <= RESP;
          chain_upd     <= 1'b0;
          bus.rsp_valid <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            busy          <= 1'b0;
          end
        end
      endcase
    end
  end

  la_cfgchain_ctrl_shreg #(
    .N   (N),
    .INV (INV)
  ) u_shreg (
    .clk     (clk),
    .rst     (reset),
    .load    (load),
    .shift   (shift),
    .word    (bus.req_data),
    .cnt     (cnt),
    .chain_q (chain_q),
    .chain_d (chain_d),
    .cap     (bus.rsp_data)
  );

endmodule

// File: tb/tb_la_cfgchain_ctrl.sv
// Bench for la_cfgchain_ctrl: N=4 inverting and N=32 plain
// chains modelled as flop arrays, random words vs model.
module tb_la_cfgchain_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  la_cfgchain_ctrl_if #(.N(4))  b4 ();
  la_cfgchain_ctrl_if #(.N(32)) b32 ();

  logic en4, d4, q4, upd4, busy4;
  logic en32, d32, q32, upd32, busy32;

  la_cfgchain_ctrl #(.N(4), .INV(1'b1), .PROP("DEFAULT")) u4 (
    .clk       (clk),
    .reset     (reset),
    .bus       (b4.slave),
    .chain_en  (en4),
    .chain_d   (d4),
    .chain_q   (q4),
    .chain_upd (upd4),
    .busy      (busy4)
  );

  la_cfgchain_ctrl #(.N(32), .INV(1'b0), .PROP("DEFAULT")) u32 (
    .clk       (clk),
    .reset     (reset),
    .bus       (b32.slave),
    .chain_en  (en32),
    .chain_d   (d32),
    .chain_q   (q32),
    .chain_upd (upd32),
    .busy      (busy32)
  );

  // Bench chains: stage 0 fed by chain_d, last stage drives chain_q
  logic [3:0]  st4;
  logic [31:0] st32;
  logic        pl4, pl32;
  logic [31:0] pv;

  always @(posedge clk)
    if (pl4) st4 <= pv[3:0];
    else if (en4) st4 <= ~{st4[2:0], d4};

  always @(posedge clk)
    if (pl32) st32 <= pv;
    else if (en32) st32 <= {st32[30:0], d32};

  assign q4  = st4[3];
  assign q32 = st32[31];

  // Views of whichever DUT is under test
  logic        sel;
  logic [31:0] v_rdy, v_en, v_d, v_upd, v_rv, v_busy, v_rsp, v_st;

  assign v_rdy  = sel ? 32'(b32.req_ready) : 32'(b4.req_ready);
  assign v_en   = sel ? 32'(en32) : 32'(en4);
  assign v_d    = sel ? 32'(d32) : 32'(d4);
  assign v_upd  = sel ? 32'(upd32) : 32'(upd4);
  assign v_rv   = sel ? 32'(b32.rsp_valid) : 32'(b4.rsp_valid);
  assign v_busy = sel ? 32'(busy32) : 32'(busy4);
  assign v_rsp  = sel ? b32.rsp_data : 32'(b4.rsp_data);
  assign v_st   = sel ? st32 : 32'(st4);

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] v);
    pv = v;
    if (sel) pl32 = 1'b1;
    else pl4 = 1'b1;
    tick();
    pl4  = 1'b0;
    pl32 = 1'b0;
  endtask

  task automatic set_req(input logic v, input logic [31:0] w);
    if (sel) begin
      b32.req_valid = v;
      b32.req_data  = w;
    end else begin
      b4.req_valid = v;
      b4.req_data  = w[3:0];
    end
  endtask

  task automatic set_rr(input logic r);
    if (sel) b32.rsp_ready = r;
    else b4.rsp_ready = r;
  endtask

  // One full request/response; hold = rsp_ready low cycles in RESP
  task automatic txn(input logic [31:0] w, input int hold,
                     input bit b2b);
    int          n;
    logic        inv;
    logic [31:0] wm, old, exp_d;
    n   = sel ? 32 : 4;
    inv = !sel;
    wm  = sel ? w : (w & 32'hF);
    old = v_st;
    check("rdy_idle", v_rdy, 32'd1);
    set_req(1'b1, wm);
    set_rr(1'b0);
    tick();
    for (int k = 0; k < n; k++) begin
      int j;
      j = n - 1 - k;
      exp_d = 32'(wm[j] ^ (inv & (j % 2 == 0)));
      set_req(b2b, $urandom);
      check("shift_en", v_en, 32'd1);
      check("shift_d", v_d, exp_d);
      check("shift_upd", v_upd, 32'd0);
      check("shift_busy", v_busy, 32'd1);
      check("shift_rdy", v_rdy, 32'd0);
      if (b2b) set_rr(1'($urandom_range(0, 1)));
      tick();
    end
    check("upd", v_upd, 32'd1);
    check("upd_en", v_en, 32'd0);
    check("upd_d", v_d, 32'd0);
    check("upd_rv", v_rv, 32'd0);
    check("chain_val", v_st, wm);
    if (b2b) set_rr(1'($urandom_range(0, 1)));
    tick();
    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid", v_rv, 32'd1);
      check("rsp_data", v_rsp, old);
      check("rsp_rdy", v_rdy, 32'd0);
      check("rsp_upd", v_upd, 32'd0);
      if (h == hold) begin
        set_rr(1'b1);
        set_req(b2b, $urandom);
      end else begin
        set_rr(1'b0);
        set_req(b2b | (h % 2 == 1), $urandom);
      end
      tick();
    end
    set_rr(1'b0);
    check("post_rv", v_rv, 32'd0);
    check("post_rdy", v_rdy, 32'd1);
    check("post_busy", v_busy, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    reset = 1'b1;
    sel = 1'b0;
    pl4 = 1'b0;
    pl32 = 1'b0;
    pv = '0;
    b4.req_valid = 1'b0;  b4.req_data = '0;  b4.rsp_ready = 1'b0;
    b32.req_valid = 1'b0; b32.req_data = '0; b32.rsp_ready = 1'b0;
    tick();
    tick();
    check("rst_rdy4", 32'(b4.req_ready), 32'd1);
    check("rst_rdy32", 32'(b32.req_ready), 32'd1);
    check("rst_en4", 32'(en4), 32'd0);
    check("rst_d32", 32'(d32), 32'd0);
    check("rst_rv4", 32'(b4.rsp_valid), 32'd0);
    check("rst_rsp32", b32.rsp_data, 32'd0);
    check("rst_busy32", 32'(busy32), 32'd0);
    check("rst_upd4", 32'(upd4), 32'd0);
    reset = 1'b0;
    tick();

    // N=4 inverting chain: directed cases
    sel = 1'b0;
    preload(32'h0);
    txn(32'hA, 0, 1'b0);
    preload(32'h3);
    txn(32'h0, 0, 1'b0);
    txn(32'h6, 10, 1'b0);

    // Abort mid-shift with async reset
    preload(32'h0);
    set_req(1'b1, 32'h5);
    tick();
    set_req(1'b0, 32'h0);
    tick();
    tick();
    check("pre_rst_en", v_en, 32'd1);
    reset = 1'b1;
    #1;
    check("arst_rdy", v_rdy, 32'd1);
    check("arst_en", v_en, 32'd0);
    check("arst_busy", v_busy, 32'd0);
    check("arst_upd", v_upd, 32'd0);
    check("arst_rsp", v_rsp, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_upd", v_upd, 32'd0);
    txn(32'h9, 2, 1'b0);

    // N=32 plain chain
    sel = 1'b1;
    preload(32'h6);
    txn(32'hC, 0, 1'b0);
    check("ro_prev", b32.rsp_data, 32'h6);
    for (int i = 0; i < 32; i++) begin
      w = $urandom;
      txn(w, $urandom_range(0, 3), 1'b1);
    end
    set_req(1'b0, 32'h0);
    tick();
    check("end_busy", v_busy, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
